// File: rtl/pid_pkg.sv
// Shared definitions for the PID gain loader and the PID controller:
// load-sequence states, gain-code width and named gain codes.
package pid_pkg;

  localparam int GAIN_CODE_W = 4;

  typedef logic [GAIN_CODE_W-1:0] gain_code_t;

  typedef enum logic [2:0] {
    ST_HOLD_RST = 3'd0,
    ST_SEND_KP  = 3'd1,
    ST_SEND_KI  = 3'd2,
    ST_SEND_KD  = 3'd3,
    ST_RUN      = 3'd4
  } state_e;

  localparam gain_code_t CODE_GAIN_0P0 = 4'd0;
  localparam gain_code_t CODE_GAIN_0P5 = 4'd5;
  localparam gain_code_t CODE_GAIN_1P0 = 4'd10;

  // Gain codes travel on the low nibble of the 8-bit setpoint bus.
  function automatic logic [7:0] code_to_bus(input gain_code_t code);
    return {4'h0, code};
  endfunction

endpackage

// File: rtl/setpoint_slew_limiter.sv
// Combinational slew limiter: moves sp_cur toward sp_target by at most
// SLEW_STEP without overshooting.
module setpoint_slew_limiter #(
  parameter int unsigned SLEW_STEP = 4
) (
  input  logic [7:0] sp_cur,
  input  logic [7:0] sp_target,
  output logic [7:0] sp_next
);

  localparam logic [7:0] STEP = 8'(SLEW_STEP);

  logic [8:0] diff_s;
  logic [7:0] mag_s;
  logic [7:0] step_s;

  // Bit 8 of the 9-bit difference is the direction (1 = cur above target).
  always_comb begin
    diff_s  = {1'b0, sp_target} - {1'b0, sp_cur};
    mag_s   = diff_s[8] ? (~diff_s[7:0] + 8'd1) : diff_s[7:0];
    step_s  = (mag_s < STEP) ? mag_s : STEP;
    sp_next = diff_s[8] ? (sp_cur - step_s) : (sp_cur + step_s);
  end

endmodule

// File: rtl/pid_gain_loader.sv
// Host-side loader: resets the PID controller, sends Kp/Ki/Kd codes on the
// setpoint bus, then streams a slew-limited setpoint.
module pid_gain_loader
  import pid_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned SLEW_STEP    = 4,
  parameter gain_code_t  DEFAULT_KP   = CODE_GAIN_1P0,
  parameter gain_code_t  DEFAULT_KI   = CODE_GAIN_0P0,
  parameter gain_code_t  DEFAULT_KD   = CODE_GAIN_0P0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [GAIN_CODE_W-1:0] cfg_kp_code,
  input  logic [GAIN_CODE_W-1:0] cfg_ki_code,
  input  logic [GAIN_CODE_W-1:0] cfg_kd_code,
  input  logic [7:0]             sp_target,
  output logic                   pid_rst_n,
  output logic [7:0]             pid_setpoint,
  output logic                   busy
);

  localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  gain_code_t       kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic [7:0]       sp_cur_q, sp_cur_d;
  logic             pid_rst_n_q, pid_rst_n_d;
  logic [7:0]       pid_setpoint_q, pid_setpoint_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             busy_q, busy_d;
  logic [7:0]       sp_next_s;
  logic             accept_s;

  setpoint_slew_limiter #(.SLEW_STEP(SLEW_STEP)) u_slew (
    .sp_cur    (sp_cur_q),
    .sp_target (sp_target),
    .sp_next   (sp_next_s)
  );

  // Next state and next registered outputs; outputs are derived from state_d.
  always_comb begin
    accept_s       = cfg_valid && cfg_ready_q;
    state_d        = state_q;
    cnt_d          = cnt_q;
    kp_d           = kp_q;
    ki_d           = ki_q;
    kd_d           = kd_q;
    sp_cur_d       = sp_cur_q;
    pid_rst_n_d    = 1'b0;
    pid_setpoint_d = 8'd0;
    cfg_ready_d    = 1'b0;
    busy_d         = 1'b1;

    case (state_q)
      ST_HOLD_RST: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_SEND_KP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SEND_KP: state_d = ST_SEND_KI;
      ST_SEND_KI: state_d = ST_SEND_KD;
      ST_SEND_KD: state_d = ST_RUN;
      ST_RUN: begin
        if (accept_s) begin
          kp_d     = cfg_kp_code;
          ki_d     = cfg_ki_code;
          kd_d     = cfg_kd_code;
          sp_cur_d = 8'd0;
          cnt_d    = '0;
          state_d  = ST_HOLD_RST;
        end else begin
          sp_cur_d = sp_next_s;
        end
      end
      default: begin
        state_d = ST_HOLD_RST;
        cnt_d   = '0;
      end
    endcase

    case (state_d)
      ST_HOLD_RST: begin
        pid_rst_n_d    = 1'b0;
        pid_setpoint_d = 8'd0;
      end
      ST_SEND_KP: begin
        pid_rst_n_d    = 1'b1;
        pid_setpoint_d = code_to_bus(kp_d);
      end
      ST_SEND_KI: begin
        pid_rst_n_d    = 1'b1;
        pid_setpoint_d = code_to_bus(ki_d);
      end
      ST_SEND_KD: begin
        pid_rst_n_d    = 1'b1;
        pid_setpoint_d = code_to_bus(kd_d);
      end
      ST_RUN: begin
        pid_rst_n_d    = 1'b1;
        pid_setpoint_d = sp_cur_d;
        cfg_ready_d    = 1'b1;
        busy_d         = 1'b0;
      end
      default: begin
        pid_rst_n_d    = 1'b0;
        pid_setpoint_d = 8'd0;
      end
    endcase
  end

  // State, code registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_HOLD_RST;
      cnt_q          <= '0;
      kp_q           <= DEFAULT_KP;
      ki_q           <= DEFAULT_KI;
      kd_q           <= DEFAULT_KD;
      sp_cur_q       <= 8'd0;
      pid_rst_n_q    <= 1'b0;
      pid_setpoint_q <= 8'd0;
      cfg_ready_q    <= 1'b0;
      busy_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      kp_q           <= kp_d;
      ki_q           <= ki_d;
      kd_q           <= kd_d;
      sp_cur_q       <= sp_cur_d;
      pid_rst_n_q    <= pid_rst_n_d;
      pid_setpoint_q <= pid_setpoint_d;
      cfg_ready_q    <= cfg_ready_d;
      busy_q         <= busy_d;
    end
  end

  assign cfg_ready    = cfg_ready_q;
  assign pid_rst_n    = pid_rst_n_q;
  assign pid_setpoint = pid_setpoint_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_pid_gain_loader.sv
// Directed scoreboard bench for pid_gain_loader: expected per-cycle outputs are
// queued as stimulus is applied and compared one cycle at a time.
module tb_pid_gain_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic [3:0] cfg_kp_code, cfg_ki_code, cfg_kd_code;
  logic [7:0] sp_target;
  logic       cfg_ready, pid_rst_n, busy;
  logic [7:0] pid_setpoint;

  logic       cfg_valid2;
  logic [3:0] code2;
  logic [7:0] sp_target2;
  logic       cfg_ready2, pid_rst_n2, busy2;
  logic [7:0] pid_setpoint2;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  typedef struct {
    string      tag;
    logic       rst_n;
    logic [7:0] sp;
    logic       rdy;
    logic       bsy;
    logic       has2;
    logic [7:0] sp2;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pid_gain_loader dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_kp_code(cfg_kp_code), .cfg_ki_code(cfg_ki_code), .cfg_kd_code(cfg_kd_code),
    .sp_target(sp_target), .pid_rst_n(pid_rst_n), .pid_setpoint(pid_setpoint),
    .busy(busy)
  );

  pid_gain_loader #(.SLEW_STEP(255)) dut2 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2),
    .cfg_kp_code(code2), .cfg_ki_code(code2), .cfg_kd_code(code2),
    .sp_target(sp_target2), .pid_rst_n(pid_rst_n2), .pid_setpoint(pid_setpoint2),
    .busy(busy2)
  );

  function automatic int slew(input int cur, input int tgt, input int step);
    if (tgt > cur) return (tgt - cur > step) ? cur + step : tgt;
    else if (cur > tgt) return (cur - tgt > step) ? cur - step : tgt;
    else return cur;
  endfunction

  task automatic push(input string tag, input logic rn, input logic [7:0] sp,
                      input logic rdy, input logic bsy);
    exp_t e;
    e.tag = tag; e.rst_n = rn; e.sp = sp; e.rdy = rdy; e.bsy = bsy;
    e.has2 = 1'b0; e.sp2 = 8'd0;
    sb.push_back(e);
  endtask

  task automatic push2(input string tag, input logic [7:0] sp, input logic [7:0] sp2);
    exp_t e;
    e.tag = tag; e.rst_n = 1'b1; e.sp = sp; e.rdy = 1'b1; e.bsy = 1'b0;
    e.has2 = 1'b1; e.sp2 = sp2;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      fail_cnt++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".pid_rst_n"}, 32'(pid_rst_n), 32'(e.rst_n));
      chk({e.tag, ".pid_setpoint"}, 32'(pid_setpoint), 32'(e.sp));
      chk({e.tag, ".cfg_ready"}, 32'(cfg_ready), 32'(e.rdy));
      chk({e.tag, ".busy"}, 32'(busy), 32'(e.bsy));
      if (e.has2) chk({e.tag, ".slew255"}, 32'(pid_setpoint2), 32'(e.sp2));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic ramp_to(input string tag, input int start, input int tgt);
    int cur;
    cur = start;
    sp_target = 8'(tgt);
    while (cur != tgt) begin
      cur = slew(cur, tgt, 4);
      push(tag, 1'b1, 8'(cur), 1'b1, 1'b0);
      tick();
    end
    push({tag, "_hold"}, 1'b1, 8'(tgt), 1'b1, 1'b0);
    tick();
  endtask

  initial begin
    logic [7:0] t2 [4];
    t2[0] = 8'd200; t2[1] = 8'd17; t2[2] = 8'd255; t2[3] = 8'd0;

    rst = 1'b1; cfg_valid = 1'b0; cfg_valid2 = 1'b0; code2 = 4'd0;
    cfg_kp_code = 4'd0; cfg_ki_code = 4'd0; cfg_kd_code = 4'd0;
    sp_target = 8'd10; sp_target2 = 8'd0;

    repeat (2) @(posedge clk);
    #1;
    push("reset", 1'b0, 8'd0, 1'b0, 1'b1);
    compare_front();

    // Release: defaults 10,0,0 in cycles 2..4, RUN from cycle 5, ramp to 10.
    rst = 1'b0;
    push("rel_hold", 1'b0, 8'd0, 1'b0, 1'b1);
    push("rel_kp", 1'b1, 8'd10, 1'b0, 1'b1);
    push("rel_ki", 1'b1, 8'd0, 1'b0, 1'b1);
    push("rel_kd", 1'b1, 8'd0, 1'b0, 1'b1);
    push("run_entry", 1'b1, 8'd0, 1'b1, 1'b0);
    push("ramp4", 1'b1, 8'd4, 1'b1, 1'b0);
    push("ramp8", 1'b1, 8'd8, 1'b1, 1'b0);
    push("ramp10", 1'b1, 8'd10, 1'b1, 1'b0);
    push("ramp10_hold", 1'b1, 8'd10, 1'b1, 1'b0);
    repeat (9) tick();

    // Accept kp=5 ki=3 kd=1; target change must be ignored while loading.
    cfg_valid = 1'b1; cfg_kp_code = 4'd5; cfg_ki_code = 4'd3; cfg_kd_code = 4'd1;
    push("acc_hold0", 1'b0, 8'd0, 1'b0, 1'b1);
    tick();
    cfg_valid = 1'b0; sp_target = 8'd200;
    push("acc_hold1", 1'b0, 8'd0, 1'b0, 1'b1);
    push("acc_kp5", 1'b1, 8'd5, 1'b0, 1'b1);
    push("acc_ki3", 1'b1, 8'd3, 1'b0, 1'b1);
    push("acc_kd1", 1'b1, 8'd1, 1'b0, 1'b1);
    push("acc_run0", 1'b1, 8'd0, 1'b1, 1'b0);
    repeat (5) tick();

    ramp_to("up200", 0, 200);
    ramp_to("down0", 200, 0);
    ramp_to("up255", 0, 255);

    // cfg_valid held through loading: re-accepted exactly on first RUN cycle.
    cfg_valid = 1'b1; cfg_kp_code = 4'd7; cfg_ki_code = 4'd2; cfg_kd_code = 4'd9;
    push("b2b_hold0", 1'b0, 8'd0, 1'b0, 1'b1);
    tick();
    cfg_kp_code = 4'd6; cfg_ki_code = 4'd6; cfg_kd_code = 4'd6;
    push("b2b_hold1", 1'b0, 8'd0, 1'b0, 1'b1);
    push("b2b_kp7", 1'b1, 8'd7, 1'b0, 1'b1);
    push("b2b_ki2", 1'b1, 8'd2, 1'b0, 1'b1);
    push("b2b_kd9", 1'b1, 8'd9, 1'b0, 1'b1);
    push("b2b_run0", 1'b1, 8'd0, 1'b1, 1'b0);
    push("b2b_reacc", 1'b0, 8'd0, 1'b0, 1'b1);
    repeat (6) tick();
    cfg_valid = 1'b0; sp_target = 8'd0;
    push("b2b_hold2", 1'b0, 8'd0, 1'b0, 1'b1);
    push("b2b_kp6", 1'b1, 8'd6, 1'b0, 1'b1);
    push("b2b_ki6", 1'b1, 8'd6, 1'b0, 1'b1);
    repeat (3) tick();

    // Asynchronous reset during SEND_KI returns to defaults.
    #2 rst = 1'b1;
    #1;
    push("midrst", 1'b0, 8'd0, 1'b0, 1'b1);
    compare_front();
    @(posedge clk);
    #1 rst = 1'b0;
    push("rst2_hold", 1'b0, 8'd0, 1'b0, 1'b1);
    push("rst2_kp", 1'b1, 8'd10, 1'b0, 1'b1);
    push("rst2_ki", 1'b1, 8'd0, 1'b0, 1'b1);
    push("rst2_kd", 1'b1, 8'd0, 1'b0, 1'b1);
    push2("rst2_run", 8'd0, 8'd0);
    repeat (5) tick();

    // SLEW_STEP=255 instance reaches any target in one step.
    for (int i = 0; i < 4; i++) begin
      sp_target2 = t2[i];
      push2("slew255", 8'd0, t2[i]);
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/pid_gain_loader.md
# pid_gain_loader

Host-side companion to the PID controller. It drives the controller's active-low reset and its 8-bit setpoint bus, covering both the start-up gain fetch and the normal setpoint stream. After any reset or gain update it pulses the controller reset, then presents the Kp, Ki and Kd 4-bit gain codes on three consecutive cycles. It then streams a slew-limited setpoint toward the host target.

## Interface

- `RESET_CYCLES`, default 2: cycles `pid_rst_n` is held low per load sequence; must be ≥1.
- `SLEW_STEP`, default 4: maximum change of `pid_setpoint` per cycle in RUN; range 1..255.
- `DEFAULT_KP`, default 4'd10: Kp code loaded after block reset (gain 1.0).
- `DEFAULT_KI`, default 4'd0: Ki code loaded after block reset.
- `DEFAULT_KD`, default 4'd0: Kd code loaded after block reset.

Ports:

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  host offers a new gain set.
- `cfg_ready`  out  1  block accepts a gain set; high only in RUN.
- `cfg_kp_code`  in  4  Kp code, sampled on accept.
- `cfg_ki_code`  in  4  Ki code, sampled on accept.
- `cfg_kd_code`  in  4  Kd code, sampled on accept.
- `sp_target`  in  8  unsigned desired setpoint.
- `pid_rst_n`  out  1  active-low reset to the controller.
- `pid_setpoint`  out  8  controller setpoint bus; carries gain codes during load.
- `busy`  out  1  high in every state except RUN.

## Operation

- All outputs are registered.
- Reset values: `pid_rst_n`=0, `pid_setpoint`=0, `cfg_ready`=0, `busy`=1, state=HOLD_RST, hold counter=0.
- On reset, the code registers take the `DEFAULT_*` values and `sp_cur`=0.
- States and transitions:
  - HOLD_RST: `pid_rst_n`=0 and `pid_setpoint`=0. The counter increments each cycle. At count `RESET_CYCLES`-1 the block goes to SEND_KP.
  - SEND_KP: `pid_rst_n`=1, `pid_setpoint`={4'h0, kp_code}. Next state is SEND_KI.
  - SEND_KI: `pid_setpoint`={4'h0, ki_code}. Next state is SEND_KD.
  - SEND_KD: `pid_setpoint`={4'h0, kd_code}. Next state is RUN.
  - RUN: `pid_setpoint`=`sp_cur` and `cfg_ready`=1.
- Each RUN edge updates `sp_cur`:
  - if `sp_cur` < `sp_target`, it moves up by min(`SLEW_STEP`, `sp_target`−`sp_cur`);
  - if `sp_cur` > `sp_target`, it moves down by the same rule;
  - if equal, it holds.
- Slew arithmetic uses a 9-bit unsigned difference. No overflow or wrap is possible and the result never overshoots the target.
- Accept: `cfg_valid`&&`cfg_ready` at an edge.
  - Latch the three codes.
  - Clear `sp_cur` to 0 and the counter to 0.
  - Go to HOLD_RST. The RUN update for that edge is discarded.
- `cfg_valid` outside RUN is ignored (`cfg_ready`=0). The host must hold it until accepted.
- `sp_target` is ignored outside RUN. Ramping always restarts from 0 after a load.
- If `rst` is asserted mid-sequence, the block returns to HOLD_RST with the default codes. Host-written codes are lost.

## Timing

- The controller samples each code on the edge that ends the corresponding SEND state. Codes must be stable for that full cycle.
- `pid_rst_n` rises at the same edge that presents the Kp code. The first edge with the controller out of reset samples Kp.
- Latency from accept edge to first RUN cycle is `RESET_CYCLES`+3 cycles. With defaults this is 5 cycles.
- After `rst` deassertion, the first RUN cycle is cycle `RESET_CYCLES`+3.
- The first RUN cycle shows `pid_setpoint`=0. The first ramp step appears one cycle later.
- `busy` falls at the same edge `cfg_ready` rises.
- Back-to-back gain sets: a new accept is possible on the first RUN cycle.

## Structure

- `pid_pkg` holds:
  - the state encoding: HOLD_RST, SEND_KP, SEND_KI, SEND_KD, RUN;
  - the 4-bit gain-code width;
  - named code constants, for example CODE_GAIN_1P0=4'd10.
- The controller reuses this package's code constants.
- One sub-module, `setpoint_slew_limiter`:
  - combinational next value from (`sp_cur`, `sp_target`, `SLEW_STEP`);
  - instantiated once and unit-testable alone.

## Test plan

- Reset release, defaults: codes 10, 0, 0 appear on `pid_setpoint` in cycles 2, 3, 4 after release. `pid_rst_n`=1 from cycle 2 and `busy`=0 from cycle 5.
- Accept kp=5, ki=3, kd=1 in RUN:
  - `pid_rst_n`=0 for exactly 2 cycles;
  - then `pid_setpoint`=5, 3, 1;
  - then 0;
  - `cfg_ready`=0 throughout.
- Ramp up: `sp_target`=10, `SLEW_STEP`=4. From RUN entry `pid_setpoint` goes 0, 4, 8, 10, 10.
- Ramp down and edges:
  - `sp_target` 200→0 gives steps of 4 down to 0 with no underflow;
  - `sp_target`=255 ends exactly at 255;
  - `SLEW_STEP`=255 reaches any target in one step.
- Handshake and reset edge cases:
  - `cfg_valid` held during HOLD_RST is accepted only on the first RUN cycle;
  - `rst` pulsed during SEND_KI restarts from HOLD_RST with default codes.
